// File: rtl/gf2_tcm3_serial_mul.sv
// Digit-serial GF(2)[x] multiplier: operands split into three K-bit limbs, five carry-less
// limb-product accumulators filled D bits per cycle, then shift-XOR recombined and piped out.
module gf2_tcm3_serial_mul #(
  parameter int N    = 409,
  parameter int D    = 1,
  parameter int PIPE = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] c
);
  localparam int K    = (N + 2) / 3;
  localparam int ITER = (K + D - 1) / D;
  localparam int CW   = $clog2(ITER + 1);
  localparam int AW   = 2 * K - 1;
  localparam int XW   = 3 * K;
  localparam int RW   = 2 * N;

  typedef enum logic [1:0] {IDLE, MUL, COMB} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [XW-1:0] a_ext, b_ext;
  logic [K-1:0]  a0_s, a1_s, a2_s;   // a-limbs, consumed D bits per iteration from the bottom
  logic [AW-1:0] b0_s, b1_s, b2_s;   // b-limbs, pre-shifted by the current digit position
  logic [AW-1:0] d_acc, e_acc, f_acc, g_acc, h_acc;

  logic [RW-1:0] pipe_data [0:PIPE];
  logic [PIPE:0] pipe_vld;

  assign a_ext = XW'(a);
  assign b_ext = XW'(b);

  // Carry-less product of the low D bits of x with y, y already aligned to the digit.
  function automatic logic [AW-1:0] digit_mul(input logic [K-1:0] x, input logic [AW-1:0] y);
    logic [AW-1:0] p;
    p = '0;
    for (int t = 0; t < D; t++)
      if (x[t]) p ^= y << t;
    return p;
  endfunction

  function automatic logic [RW-1:0] recombine(input logic [AW-1:0] dd, ee, ff, gg, hh);
    return RW'(hh) ^ (RW'(gg) << K) ^ (RW'(ff) << (2 * K)) ^ (RW'(ee) << (3 * K))
         ^ (RW'(dd) << (4 * K));
  endfunction

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (cnt == CW'(ITER - 1)) state_nxt = COMB;
      COMB:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      a0_s  <= '0;
      a1_s  <= '0;
      a2_s  <= '0;
      b0_s  <= '0;
      b1_s  <= '0;
      b2_s  <= '0;
      d_acc <= '0;
      e_acc <= '0;
      f_acc <= '0;
      g_acc <= '0;
      h_acc <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          a0_s  <= a_ext[K-1:0];
          a1_s  <= a_ext[2*K-1:K];
          a2_s  <= a_ext[3*K-1:2*K];
          b0_s  <= AW'(b_ext[K-1:0]);
          b1_s  <= AW'(b_ext[2*K-1:K]);
          b2_s  <= AW'(b_ext[3*K-1:2*K]);
          d_acc <= '0;
          e_acc <= '0;
          f_acc <= '0;
          g_acc <= '0;
          h_acc <= '0;
        end
        MUL: begin
          cnt   <= cnt + CW'(1);
          h_acc <= h_acc ^ digit_mul(a0_s, b0_s);
          g_acc <= g_acc ^ digit_mul(a0_s, b1_s) ^ digit_mul(a1_s, b0_s);
          f_acc <= f_acc ^ digit_mul(a0_s, b2_s) ^ digit_mul(a1_s, b1_s) ^ digit_mul(a2_s, b0_s);
          e_acc <= e_acc ^ digit_mul(a1_s, b2_s) ^ digit_mul(a2_s, b1_s);
          d_acc <= d_acc ^ digit_mul(a2_s, b2_s);
          // Past bit K-1 the a-limbs are zero, so b bits shifted off the top never matter.
          a0_s  <= a0_s >> D;
          a1_s  <= a1_s >> D;
          a2_s  <= a2_s >> D;
          b0_s  <= b0_s << D;
          b1_s  <= b1_s << D;
          b2_s  <= b2_s << D;
        end
        default: ;
      endcase
    end
  end

  // Stage 0 is the recombination register; data only moves with a valid result so c holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      // NOTE: this storage array is reset explicitly because a reset must wipe in-flight results.
      for (int s = 0; s <= PIPE; s++) pipe_data[s] <= '0;
    end else begin
      pipe_vld[0] <= (state == COMB);
      if (state == COMB) pipe_data[0] <= recombine(d_acc, e_acc, f_acc, g_acc, h_acc);
      for (int s = 1; s <= PIPE; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        if (pipe_vld[s-1]) pipe_data[s] <= pipe_data[s-1];
      end
    end
  end

  assign done = pipe_vld[PIPE];
  assign c    = pipe_data[PIPE];

endmodule

// File: tb/tb_gf2_tcm3_serial_mul.sv
// Bench for gf2_tcm3_serial_mul: three configurations checked against a plain carry-less
// multiply, with latency, handshake and mid-operation reset scenarios.
module tb_gf2_tcm3_serial_mul;
  localparam int NB  = 409;
  localparam int CWB = 2 * NB;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     start_v;
  logic [NB-1:0]  a_w, b_w;
  logic [2:0]     ready_v, done_v;
  logic [CWB-1:0] c0, c1;
  logic [19:0]    c2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf2_tcm3_serial_mul #(.N(409), .D(1), .PIPE(3)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_w), .b(b_w),
    .ready(ready_v[0]), .done(done_v[0]), .c(c0));

  gf2_tcm3_serial_mul #(.N(409), .D(7), .PIPE(0)) u_d7 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_w), .b(b_w),
    .ready(ready_v[1]), .done(done_v[1]), .c(c1));

  gf2_tcm3_serial_mul #(.N(10), .D(3), .PIPE(3)) u_n10 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_w[9:0]), .b(b_w[9:0]),
    .ready(ready_v[2]), .done(done_v[2]), .c(c2));

  // Expected configuration figures: N, ITER and total latency L = ITER + 1 + PIPE.
  function automatic int n_of(input int w);
    return (w == 2) ? 10 : 409;
  endfunction

  function automatic int iter_of(input int w);
    case (w)
      0:       return 137;
      1:       return 20;
      default: return 2;
    endcase
  endfunction

  function automatic int l_of(input int w);
    case (w)
      0:       return 141;
      1:       return 21;
      default: return 6;
    endcase
  endfunction

  function automatic logic [CWB-1:0] get_c(input int w);
    case (w)
      0:       return c0;
      1:       return c1;
      default: return CWB'(c2);
    endcase
  endfunction

  // Reference: schoolbook carry-less product, one shifted copy of y per set bit of x.
  function automatic logic [CWB-1:0] clmul(input logic [NB-1:0] x, input logic [NB-1:0] y);
    logic [CWB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      if (x[i]) r ^= CWB'(y) << i;
    return r;
  endfunction

  function automatic logic [NB-1:0] rnd();
    logic [NB-1:0] t;
    for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
    t[408:384] = 25'($urandom);
    return t;
  endfunction

  task automatic check(input string tag, input logic [CWB-1:0] obs, input logic [CWB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on DUT w: accept, scramble inputs, time done, compare product.
  task automatic run_op(input int w, input logic [NB-1:0] x, input logic [NB-1:0] y,
                        output logic [CWB-1:0] got);
    logic [NB-1:0]  msk;
    logic [CWB-1:0] exp;
    int k;
    msk = {NB{1'b1}} >> (NB - n_of(w));
    exp = clmul(x & msk, y & msk);
    @(negedge clk);
    check($sformatf("ready_idle_w%0d", w), CWB'(ready_v[w]), CWB'(1));
    a_w = x;
    b_w = y;
    start_v[w] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[w] = 1'b0;
    a_w = rnd();
    b_w = rnd();
    check($sformatf("ready_busy_w%0d", w), CWB'(ready_v[w]), '0);
    k = 0;
    while (!done_v[w] && k < l_of(w) + 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check($sformatf("latency_w%0d", w), CWB'(k), CWB'(l_of(w)));
    got = get_c(w);
    check($sformatf("product_w%0d", w), got, exp);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("done_pulse_w%0d", w), CWB'(done_v[w]), '0);
    check($sformatf("c_hold_w%0d", w), get_c(w), exp);
  endtask

  initial begin
    logic [CWB-1:0] got;
    logic [CWB-1:0] exp;
    logic [NB-1:0]  x, y;
    logic [CWB-1:0] q[$];
    int accepts, dones, prev_acc;
    logic prev_done, acc_now;

    rst = 1'b1;
    start_v = '0;
    a_w = '0;
    b_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("rst_ready_w%0d", w), CWB'(ready_v[w]), CWB'(1));
      check($sformatf("rst_done_w%0d", w), CWB'(done_v[w]), '0);
      check($sformatf("rst_c_w%0d", w), get_c(w), '0);
    end

    // Directed minimal and boundary operands.
    run_op(0, NB'(3), NB'(3), got);
    check("x2_plus_1", got, CWB'(5));
    run_op(0, NB'(1), NB'(0), got);
    check("times_zero", got, '0);
    x = NB'(1) << 408;
    run_op(0, x, x, got);
    check("top_limb", got, CWB'(1) << 816);
    x = '1;
    run_op(0, x, x, got);
    check("msb_zero_d1", CWB'(got[CWB-1]), '0);
    run_op(1, x, x, got);
    check("msb_zero_d7", CWB'(got[CWB-1]), '0);
    run_op(2, x, x, got);
    check("msb_zero_n10", got >> 19, '0);

    // Random sweep over the three configurations.
    for (int i = 0; i < 40; i++) run_op(0, rnd(), rnd(), got);
    for (int i = 0; i < 200; i++) run_op(1, rnd(), rnd(), got);
    for (int i = 0; i < 200; i++) run_op(2, rnd(), rnd(), got);

    // start held high: back-to-back accepts every ITER+2 cycles, results in order.
    accepts = 0;
    dones = 0;
    prev_acc = -1;
    prev_done = 1'b0;
    @(negedge clk);
    a_w = rnd();
    b_w = rnd();
    start_v[1] = 1'b1;
    for (int cyc = 0; cyc < 200 && dones < 4; cyc++) begin
      if (done_v[1]) begin
        dones++;
        check("hs_done_width", CWB'(prev_done), '0);
        exp = (q.size() > 0) ? q.pop_front() : ~c1;
        check("hs_order", c1, exp);
      end
      prev_done = done_v[1];
      acc_now = ready_v[1] && start_v[1];
      if (acc_now) begin
        q.push_back(clmul(a_w, b_w));
        if (prev_acc >= 0) check("hs_interval", CWB'(cyc - prev_acc), CWB'(iter_of(1) + 2));
        prev_acc = cyc;
        accepts++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc_now) begin
        a_w = rnd();
        b_w = rnd();
        if (accepts == 4) start_v[1] = 1'b0;
      end
    end
    check("hs_dones", CWB'(dones), CWB'(4));
    check("hs_queue_empty", CWB'(q.size()), '0);

    // start pulses while busy are ignored: exactly one done, for the accepted operands.
    x = rnd();
    y = rnd();
    @(negedge clk);
    a_w = x;
    b_w = y;
    start_v[1] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_w = rnd();
      b_w = rnd();
    end
    start_v[1] = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[1]) begin
        dones++;
        check("ign_product", c1, clmul(x, y));
      end
    end
    check("ign_single_done", CWB'(dones), CWB'(1));
    check("ign_ready_after", CWB'(ready_v[1]), CWB'(1));

    // Reset during MUL iteration 50.
    run_op(0, NB'(3), NB'(3), got);
    @(negedge clk);
    a_w = rnd();
    b_w = rnd();
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mul_done", CWB'(done_v[0]), '0);
    check("rst_mul_c", c0, '0);
    check("rst_mul_ready", CWB'(ready_v[0]), CWB'(1));
    dones = 0;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check("rst_mul_no_done", CWB'(dones), '0);

    // Reset with a result sitting in pipeline stage 1.
    run_op(0, NB'(3), NB'(3), got);
    @(negedge clk);
    a_w = rnd();
    b_w = rnd();
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (iter_of(0) + 2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_pipe_done", CWB'(done_v[0]), '0);
    check("rst_pipe_c", c0, '0);
    check("rst_pipe_ready", CWB'(ready_v[0]), CWB'(1));
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check("rst_pipe_no_done", CWB'(dones), '0);
    run_op(0, NB'(3), NB'(3), got);
    check("post_rst_product", got, CWB'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
